// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush controller.
package pipeline_hazard_ctrl_pkg;

  localparam int unsigned REG_FILE_DEPTH = 4;
  localparam int unsigned WORD_WIDTH     = 32;
  // Wait-state counter width; covers MEM_WAIT up to 15.
  localparam int unsigned MEM_CNT_W      = 4;

  typedef enum logic {
    StIdle = 1'b0,
    StWait = 1'b1
  } mem_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_sram_wait_fsm.sv
// SRAM wait-state FSM: stalls the whole pipeline for MemWait cycles per access,
// then pulses mem_ready_o for one completion cycle.
module sram_wait_fsm
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MemWait = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic mem_access_i,
  output logic stall_all_o,
  output logic mem_ready_o
);

  localparam logic [MEM_CNT_W-1:0] CntLoad = MEM_CNT_W'(MemWait - 1);

  mem_state_e           state_q, state_d;
  logic [MEM_CNT_W-1:0] cnt_q, cnt_d;

  // State and wait counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and stall/ready decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_all_o = 1'b0;
    mem_ready_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mem_access_i) begin
          stall_all_o = 1'b1;
          state_d     = StWait;
          cnt_d       = CntLoad;
        end
      end
      StWait: begin
        if (cnt_q != '0) begin
          stall_all_o = 1'b1;
          cnt_d       = cnt_q - 1'b1;
        end else begin
          // Pipeline advances this cycle, so a held MEM_Access is a new access.
          mem_ready_o = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: RAW hazard detect,
// branch flush and SRAM wait-state stall, plus a saturating stall counter.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_IDX_W = REG_FILE_DEPTH,
  parameter int unsigned MEM_WAIT  = 3,
  parameter bit          FWD_EN    = 1'b1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ID_Valid,
  input  logic [REG_IDX_W-1:0] ID_Rn,
  input  logic [REG_IDX_W-1:0] ID_Rm,
  input  logic                 ID_Use_Rn,
  input  logic                 ID_Two_Src,
  input  logic [REG_IDX_W-1:0] EX_Dest,
  input  logic                 EX_WB_EN,
  input  logic                 EX_MEM_R_EN,
  input  logic [REG_IDX_W-1:0] MEM_Dest,
  input  logic                 MEM_WB_EN,
  input  logic                 MEM_Access,
  input  logic                 EX_Branch_Taken,
  output logic                 Freeze_PC,
  output logic                 ID_Flush,
  output logic                 IF_Flush,
  output logic                 Stall_All,
  output logic                 Mem_Ready,
  output logic [CNT_W-1:0]     Stall_Count
);

  logic             fsm_stall, fsm_ready;
  logic             m_ex, m_mem, hazard, flush, stall;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  sram_wait_fsm #(
    .MemWait(MEM_WAIT)
  ) u_sram_wait_fsm (
    .clk_i       (clk),
    .rst_i       (rst),
    .mem_access_i(MEM_Access),
    .stall_all_o (fsm_stall),
    .mem_ready_o (fsm_ready)
  );

  // Hazard compare, flush and output priority (rst > stall > flush > hazard).
  always_comb begin
    m_ex  = (ID_Use_Rn && (ID_Rn == EX_Dest)) || (ID_Two_Src && (ID_Rm == EX_Dest));
    m_mem = (ID_Use_Rn && (ID_Rn == MEM_Dest)) || (ID_Two_Src && (ID_Rm == MEM_Dest));
    if (FWD_EN) begin
      // Forwarding covers everything except a load result still in EX.
      hazard = ID_Valid && EX_MEM_R_EN && EX_WB_EN && m_ex;
    end else begin
      hazard = ID_Valid && ((EX_WB_EN && m_ex) || (MEM_WB_EN && m_mem));
    end
    // Outputs are forced low while reset is held, even though the FSM resets async.
    stall     = !rst && fsm_stall;
    flush     = !rst && EX_Branch_Taken && !stall;
    Stall_All = stall;
    Mem_Ready = !rst && fsm_ready;
    IF_Flush  = flush;
    ID_Flush  = flush || (!rst && hazard && !stall);
    Freeze_PC = stall || (!rst && hazard && !flush);
  end

  // Saturating stall-cycle counter next state.
  always_comb begin
    stall_count_d = stall_count_q;
    if ((Stall_All || Freeze_PC) && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign Stall_Count = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (forwarding / no forwarding with
// a 4-bit counter) share stimulus and are checked against a behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned MemWait = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid, id_use_rn, id_two_src;
  logic [3:0] id_rn, id_rm, ex_dest, mem_dest;
  logic       ex_wb_en, ex_mem_r_en, mem_wb_en, mem_access, ex_branch_taken;

  logic        a_freeze, a_idf, a_iff, a_stall, a_ready;
  logic        b_freeze, b_idf, b_iff, b_stall, b_ready;
  logic [15:0] a_cnt;
  logic [3:0]  b_cnt;
  logic [4:0]  out_a, out_b;

  int          n_checks = 0;
  int          n_fail   = 0;

  // Model state: cycles left in the current access (0 = idle), stall counters.
  int          wait_left = 0;
  int unsigned cnt_a = 0, cnt_b = 0;

  always #5 clk = ~clk;

  assign out_a = {a_freeze, a_idf, a_iff, a_stall, a_ready};
  assign out_b = {b_freeze, b_idf, b_iff, b_stall, b_ready};

  pipeline_hazard_ctrl #(
    .REG_IDX_W(4), .MEM_WAIT(MemWait), .FWD_EN(1'b1), .CNT_W(16)
  ) u_dut_a (
    .clk(clk), .rst(rst), .ID_Valid(id_valid), .ID_Rn(id_rn), .ID_Rm(id_rm),
    .ID_Use_Rn(id_use_rn), .ID_Two_Src(id_two_src), .EX_Dest(ex_dest), .EX_WB_EN(ex_wb_en),
    .EX_MEM_R_EN(ex_mem_r_en), .MEM_Dest(mem_dest), .MEM_WB_EN(mem_wb_en),
    .MEM_Access(mem_access), .EX_Branch_Taken(ex_branch_taken), .Freeze_PC(a_freeze),
    .ID_Flush(a_idf), .IF_Flush(a_iff), .Stall_All(a_stall), .Mem_Ready(a_ready),
    .Stall_Count(a_cnt)
  );

  pipeline_hazard_ctrl #(
    .REG_IDX_W(4), .MEM_WAIT(MemWait), .FWD_EN(1'b0), .CNT_W(4)
  ) u_dut_b (
    .clk(clk), .rst(rst), .ID_Valid(id_valid), .ID_Rn(id_rn), .ID_Rm(id_rm),
    .ID_Use_Rn(id_use_rn), .ID_Two_Src(id_two_src), .EX_Dest(ex_dest), .EX_WB_EN(ex_wb_en),
    .EX_MEM_R_EN(ex_mem_r_en), .MEM_Dest(mem_dest), .MEM_WB_EN(mem_wb_en),
    .MEM_Access(mem_access), .EX_Branch_Taken(ex_branch_taken), .Freeze_PC(b_freeze),
    .ID_Flush(b_idf), .IF_Flush(b_iff), .Stall_All(b_stall), .Mem_Ready(b_ready),
    .Stall_Count(b_cnt)
  );

  function automatic logic ref_hazard(bit fwd);
    logic mex, mmem;
    mex  = (id_use_rn && id_rn == ex_dest) || (id_two_src && id_rm == ex_dest);
    mmem = (id_use_rn && id_rn == mem_dest) || (id_two_src && id_rm == mem_dest);
    if (!id_valid) return 1'b0;
    if (fwd) return ex_mem_r_en && ex_wb_en && mex;
    return (ex_wb_en && mex) || (mem_wb_en && mmem);
  endfunction

  // {Freeze_PC, ID_Flush, IF_Flush, Stall_All, Mem_Ready}
  function automatic logic [4:0] ref_outs(bit fwd);
    logic stall, ready, flush, haz;
    if (rst) return 5'b0;
    stall = (wait_left == 0) ? mem_access : (wait_left > 1);
    ready = (wait_left == 1);
    flush = ex_branch_taken && !stall;
    haz   = ref_hazard(fwd);
    return {stall || (haz && !flush), flush || (haz && !stall), flush, stall, ready};
  endfunction

  task automatic tick();
    logic [4:0] ea, eb;
    ea = ref_outs(1'b1);
    eb = ref_outs(1'b0);
    @(posedge clk);
    if (rst) begin
      wait_left = 0; cnt_a = 0; cnt_b = 0;
    end else begin
      if ((ea[4] || ea[1]) && cnt_a < 65535) cnt_a++;
      if ((eb[4] || eb[1]) && cnt_b < 15) cnt_b++;
      if (wait_left == 0) begin
        if (mem_access) wait_left = MemWait;
      end else begin
        wait_left--;
      end
    end
    #1;
  endtask

  task automatic set_rst(logic v);
    rst = v;
    if (v) begin
      wait_left = 0; cnt_a = 0; cnt_b = 0;
    end
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_use_rn = 0; id_two_src = 0; id_rn = 0; id_rm = 0;
    ex_dest = 0; mem_dest = 0; ex_wb_en = 0; ex_mem_r_en = 0; mem_wb_en = 0;
    mem_access = 0; ex_branch_taken = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    set_rst(1'b1);
    tick();
    set_rst(1'b0);
  endtask

  task automatic test_reset();
    clear_inputs();
    set_rst(1'b1);
    mem_access = 1; ex_branch_taken = 1;
    id_valid = 1; id_use_rn = 1; id_rn = 6; ex_dest = 6; ex_wb_en = 1; ex_mem_r_en = 1;
    for (int i = 0; i < 3; i++) begin
      #2;
      n_checks += 3;
      if (out_a !== 5'b0) begin
        n_fail++; $display("FAIL reset_outs_a cyc%0d actual=%b required=00000", i, out_a);
      end
      if (out_b !== 5'b0) begin
        n_fail++; $display("FAIL reset_outs_b cyc%0d actual=%b required=00000", i, out_b);
      end
      if (a_cnt !== 16'd0 || b_cnt !== 4'd0) begin
        n_fail++; $display("FAIL reset_count actual=%0d/%0d required=0/0", a_cnt, b_cnt);
      end
      tick();
    end
    clear_inputs();
    set_rst(1'b0);
    #2;
    n_checks++;
    if (out_a !== 5'b0) begin
      n_fail++; $display("FAIL release_idle actual=%b required=00000", out_a);
    end
    mem_access = 1;
    #1;
    n_checks++;
    if (out_a !== 5'b10010) begin
      n_fail++; $display("FAIL release_first_access actual=%b required=10010", out_a);
    end
  endtask

  task automatic test_mem_access();
    do_reset();
    mem_access = 1;
    for (int k = 0; k < 4; k++) begin
      #2;
      n_checks += 3;
      if (a_stall !== 1'(k < 3)) begin
        n_fail++; $display("FAIL mem_stall cyc%0d actual=%b required=%b", k, a_stall, k < 3);
      end
      if (a_ready !== 1'(k == 3)) begin
        n_fail++; $display("FAIL mem_ready cyc%0d actual=%b required=%b", k, a_ready, k == 3);
      end
      if (out_b !== ref_outs(1'b0)) begin
        n_fail++;
        $display("FAIL mem_outs_b cyc%0d actual=%b required=%b", k, out_b, ref_outs(1'b0));
      end
      tick();
    end
    mem_access = 0;
    #2;
    n_checks += 2;
    if (a_cnt !== 16'd3) begin
      n_fail++; $display("FAIL mem_count_a actual=%0d required=3", a_cnt);
    end
    if (b_cnt !== 4'd3) begin
      n_fail++; $display("FAIL mem_count_b actual=%0d required=3", b_cnt);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    id_valid = 1; id_rn = 5; id_use_rn = 1; id_rm = 9; ex_dest = 5;
    ex_wb_en = 1; ex_mem_r_en = 1;
    #2;
    n_checks += 2;
    if ({a_freeze, a_idf, a_iff} !== 3'b110) begin
      n_fail++; $display("FAIL load_use_a actual=%b required=110", {a_freeze, a_idf, a_iff});
    end
    if ({b_freeze, b_idf} !== 2'b11) begin
      n_fail++; $display("FAIL load_use_b actual=%b required=11", {b_freeze, b_idf});
    end
    ex_mem_r_en = 0;
    #1;
    n_checks += 2;
    if ({a_freeze, a_idf} !== 2'b00) begin
      n_fail++; $display("FAIL no_load_a actual=%b required=00", {a_freeze, a_idf});
    end
    if ({b_freeze, b_idf} !== 2'b11) begin
      n_fail++; $display("FAIL no_load_b actual=%b required=11", {b_freeze, b_idf});
    end
    tick();
  endtask

  task automatic test_no_fwd();
    do_reset();
    id_valid = 1; id_use_rn = 0; id_rn = 7; id_rm = 2; id_two_src = 1;
    mem_dest = 2; mem_wb_en = 1; ex_dest = 4; ex_wb_en = 1;
    #2;
    n_checks += 2;
    if ({b_freeze, b_idf} !== 2'b11) begin
      n_fail++; $display("FAIL mem_raw_b actual=%b required=11", {b_freeze, b_idf});
    end
    if (a_freeze !== 1'b0) begin
      n_fail++; $display("FAIL mem_raw_a actual=%b required=0", a_freeze);
    end
    id_two_src = 0;
    #1;
    n_checks++;
    if ({b_freeze, b_idf} !== 2'b00) begin
      n_fail++; $display("FAIL no_rm_b actual=%b required=00", {b_freeze, b_idf});
    end
    tick();
  endtask

  task automatic test_branch_hazard();
    do_reset();
    id_valid = 1; id_rn = 5; id_use_rn = 1; ex_dest = 5; ex_wb_en = 1; ex_mem_r_en = 1;
    ex_branch_taken = 1;
    #2;
    n_checks += 2;
    if (out_a !== 5'b01100) begin
      n_fail++; $display("FAIL branch_hazard_a actual=%b required=01100", out_a);
    end
    if (out_b !== 5'b01100) begin
      n_fail++; $display("FAIL branch_hazard_b actual=%b required=01100", out_b);
    end
    tick();
  endtask

  task automatic test_branch_in_wait();
    logic [4:0] req;
    do_reset();
    mem_access = 1; ex_branch_taken = 1;
    for (int k = 0; k < 4; k++) begin
      req = (k < 3) ? 5'b10010 : 5'b01101;
      #2;
      n_checks += 2;
      if (out_a !== req) begin
        n_fail++; $display("FAIL branch_wait_a cyc%0d actual=%b required=%b", k, out_a, req);
      end
      if (out_b !== req) begin
        n_fail++; $display("FAIL branch_wait_b cyc%0d actual=%b required=%b", k, out_b, req);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    mem_access = 1;
    tick();
    tick();
    #2;
    n_checks++;
    if (a_stall !== 1'b1) begin
      n_fail++; $display("FAIL mid_access_stall actual=%b required=1", a_stall);
    end
    set_rst(1'b1);
    #1;
    n_checks++;
    if (out_a !== 5'b0 || a_cnt !== 16'd0) begin
      n_fail++; $display("FAIL mid_access_rst actual=%b/%0d required=00000/0", out_a, a_cnt);
    end
    tick();
    set_rst(1'b0);
    mem_access = 0;
    #2;
    n_checks++;
    if (out_a !== 5'b0) begin
      n_fail++; $display("FAIL abandoned_access actual=%b required=00000", out_a);
    end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    id_valid = 1; id_use_rn = 1; id_rn = 3; ex_dest = 3; ex_wb_en = 1; ex_mem_r_en = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 14) begin
        n_checks++;
        if (b_cnt !== 4'd14) begin
          n_fail++; $display("FAIL sat_count_14 actual=%0d required=14", b_cnt);
        end
      end
    end
    #1;
    n_checks += 2;
    if (b_cnt !== 4'd15) begin
      n_fail++; $display("FAIL sat_count_b actual=%0d required=15", b_cnt);
    end
    if (a_cnt !== 16'd0) begin
      n_fail++; $display("FAIL sat_count_a actual=%0d required=0", a_cnt);
    end
  endtask

  task automatic test_random();
    logic [4:0] ea, eb;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      id_valid        = ($urandom_range(0, 3) != 0);
      id_use_rn       = $urandom_range(0, 1);
      id_two_src      = $urandom_range(0, 1);
      id_rn           = 4'($urandom_range(0, 3));
      id_rm           = 4'($urandom_range(0, 3));
      ex_dest         = 4'($urandom_range(0, 3));
      mem_dest        = 4'($urandom_range(0, 3));
      ex_wb_en        = $urandom_range(0, 1);
      ex_mem_r_en     = $urandom_range(0, 1);
      mem_wb_en       = $urandom_range(0, 1);
      mem_access      = ($urandom_range(0, 3) == 0);
      ex_branch_taken = ($urandom_range(0, 4) == 0);
      set_rst($urandom_range(0, 63) == 0);
      #2;
      ea = ref_outs(1'b1);
      eb = ref_outs(1'b0);
      n_checks += 4;
      if (out_a !== ea) begin
        n_fail++; $display("FAIL rand_outs_a cyc%0d actual=%b required=%b", i, out_a, ea);
      end
      if (out_b !== eb) begin
        n_fail++; $display("FAIL rand_outs_b cyc%0d actual=%b required=%b", i, out_b, eb);
      end
      if (a_cnt !== 16'(cnt_a)) begin
        n_fail++; $display("FAIL rand_count_a cyc%0d actual=%0d required=%0d", i, a_cnt, cnt_a);
      end
      if (b_cnt !== 4'(cnt_b)) begin
        n_fail++; $display("FAIL rand_count_b cyc%0d actual=%0d required=%0d", i, b_cnt, cnt_b);
      end
      tick();
    end
    set_rst(1'b0);
  endtask

  initial begin
    clear_inputs();
    #1;
    test_reset();
    test_mem_access();
    test_load_use();
    test_no_fwd();
    test_branch_hazard();
    test_branch_in_wait();
    test_reset_mid_access();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
